// File: rtl/dmem_if.sv
// dmem_if: RV32I data-memory interface stage.
// Issues one load/store per instruction on a request/grant/response port,
// stalls the pipeline until the access completes, then aligns and extends
// load data for writeback.
// Optional feature: define DMEM_TIMEOUT_EN to abort accesses that spend
// TIMEOUT_CYCLES cycles in REQ+RESP (err_o pulses on the aborting cycle).
//
// Memory handshake: d_req_o is high only in REQ and, while high, d_addr_o,
// d_we_o and d_wdata_o are held stable; the request is accepted in the cycle
// d_req_o && d_gnt_i. A load then waits in RESP for d_rvalid_i, which is
// sampled only there. d_gnt_i outside REQ and d_rvalid_i outside RESP are
// ignored.
module dmem_if #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        stall_o,
  output logic        load_ready_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        err_o,
  output logic        d_req_o,
  output logic [3:0]  d_we_o,
  output logic [31:0] d_addr_o,
  output logic [31:0] d_wdata_o,
  input  logic        d_gnt_i,
  input  logic        d_rvalid_i,
  input  logic [31:0] d_rdata_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_load_q, is_load_d;
  logic        err_q, err_d;

  logic        req_valid;
  logic        misaligned;
  logic        timeout_hit;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign req_valid = mem_read_i | mem_write_i;

  // Alignment check on the incoming request (reserved funct3 codes reject too)
  always_comb begin
    misaligned = 1'b0;
    case (funct3_i)
      3'b011, 3'b110, 3'b111: misaligned = 1'b1;
      default: begin
        if ((funct3_i[1:0] == 2'b01) && addr_i[0]) begin
          misaligned = 1'b1;
        end
        if ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)) begin
          misaligned = 1'b1;
        end
      end
    endcase
  end

  // Select the addressed byte/half of the returned word and extend it
  always_comb begin
    byte_sel = 8'h00;
    case (addr_q[1:0])
      2'd0: byte_sel = d_rdata_i[7:0];
      2'd1: byte_sel = d_rdata_i[15:8];
      2'd2: byte_sel = d_rdata_i[23:16];
      default: byte_sel = d_rdata_i[31:24];
    endcase
    half_sel = addr_q[1] ? d_rdata_i[31:16] : d_rdata_i[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h000000, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0000, half_sel};
      default: load_ext = d_rdata_i;
    endcase
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Cycle counter: held at zero in IDLE, so it starts from zero on entry to REQ
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if ((state_q == REQ) || (state_q == RESP)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = ((state_q == REQ) || (state_q == RESP)) &&
                       (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit = 1'b0;
`endif

  // FSM next-state, latched fields and port outputs
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    funct3_d     = funct3_q;
    is_load_d    = is_load_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    stall_o      = 1'b0;
    load_ready_o = 1'b0;
    misaligned_o = 1'b0;
    err_o        = 1'b0;
    d_req_o      = 1'b0;
    d_we_o       = 4'b0000;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            misaligned_o = 1'b1;
          end else begin
            addr_d    = addr_i;
            wdata_d   = wdata_i;
            be_d      = be_i;
            funct3_d  = funct3_i;
            is_load_d = mem_read_i;
            err_d     = 1'b0;
            stall_o   = 1'b1;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        stall_o = 1'b1;
        d_req_o = 1'b1;
        d_we_o  = is_load_q ? 4'b0000 : be_q;
        // A store grant completes the access; a load grant does not
        if (d_gnt_i && !is_load_q) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          err_o   = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (d_gnt_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        stall_o = 1'b1;
        if (d_rvalid_i) begin
          rdata_d = load_ext;
          state_d = DONE;
        end else if (timeout_hit) begin
          err_o   = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        load_ready_o = is_load_q && !err_q;
        state_d      = IDLE;
      end
    endcase
  end

  // State and latched-field registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      funct3_q  <= '0;
      is_load_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      funct3_q  <= funct3_d;
      is_load_q <= is_load_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign d_addr_o    = {addr_q[31:2], 2'b00};
  assign d_wdata_o   = wdata_q;
  assign rdata_o     = rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/dmem_if.md
# dmem_if

Data-memory interface stage for the RV32I core, sitting directly downstream of the load/store byte-lane decoder. It accepts one load or store per instruction from the execute/memory stage and issues it to a request/grant/response data memory port. It stalls the pipeline until the access completes, then aligns and sign- or zero-extends load data for writeback.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: cycles spent in REQ+RESP before an access is aborted; used only with DMEM_TIMEOUT_EN.

Ports:
- clk_i  in  1  core clock; all state updates on its rising edge.
- rst_n_i  in  1  reset; one clock; reset is asynchronous and active-low.
- mem_read_i  in  1  load request from the pipeline; held high while stall_o is high.
- mem_write_i  in  1  store request; mutually exclusive with mem_read_i.
- funct3_i  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- addr_i  in  32  effective byte address.
- wdata_i  in  32  store data, already lane-replicated by the byte-lane decoder.
- be_i  in  4  byte enables from the byte-lane decoder.
- stall_o  out  1  holds the pipeline while an access is in flight.
- load_ready_o  out  1  one-cycle pulse: rdata_o is valid for writeback.
- rdata_o  out  32  aligned, extended load result.
- misaligned_o  out  1  one-cycle pulse: access rejected.
- err_o  out  1  one-cycle pulse: access timed out.
- d_req_o  out  1  memory request.
- d_we_o  out  4  memory byte write enables; 0000 for loads.
- d_addr_o  out  32  word address; bits [1:0] forced to 00.
- d_wdata_o  out  32  memory write data.
- d_gnt_i  in  1  memory accepted the request this cycle.
- d_rvalid_i  in  1  read data valid this cycle.
- d_rdata_i  in  32  read data word.

## Operation
- The FSM has four states: IDLE, REQ, RESP, DONE.
- **IDLE**
  - A request is mem_read_i or mem_write_i.
  - A request is misaligned when any of these holds: funct3[1:0]=01 and addr[0]=1; funct3[1:0]=10 and addr[1:0]≠00; funct3 ∈ {011, 110, 111}.
  - Misaligned request: pulse misaligned_o, issue nothing, stay in IDLE, stall_o=0.
  - Aligned request: latch addr, wdata, be, funct3, and read/write; go to REQ. stall_o=1 combinationally in this cycle.
- **REQ**
  - Drives d_req_o=1 with the latched fields, held stable until d_gnt_i.
  - d_we_o = be for a store, 0000 for a load.
  - On d_gnt_i: a store goes to DONE; a load goes to RESP.
- **RESP**
  - d_req_o=0. Wait for d_rvalid_i, then capture the extended data into rdata_o and go to DONE.
- **DONE**
  - stall_o=0. load_ready_o=1 if the access was a load. Return to IDLE.
  - The pipeline advances in this cycle, so the next request is seen in IDLE.
- **Load extension** selects the byte or half of d_rdata_i using addr[1:0] (half uses addr[1]):
  - LB sign-extends bit 7 of the byte; LBU zero-extends the byte.
  - LH sign-extends bit 15 of the half; LHU zero-extends the half.
  - LW passes the word through.
- rdata_o holds its value until the next load capture.
- d_rvalid_i is ignored outside RESP.
- d_gnt_i is ignored outside REQ.

## Timing
- Reset values: state IDLE; d_req_o=0, d_we_o=0, d_addr_o=0, d_wdata_o=0, rdata_o=0, all pulses 0.
- stall_o is 0 after reset; afterwards it follows the rules above.
- Store with same-cycle grant: IDLE(accept), REQ(gnt), DONE. stall_o is high for 2 cycles.
- Load with gnt in REQ and rvalid in the next cycle: IDLE, REQ, RESP, DONE. stall_o is high for 3 cycles; load_ready_o pulses in cycle 3.
- Each cycle of grant or rvalid delay adds one stall cycle.
- Reset asserted mid-access:
  - Immediately: state IDLE and d_req_o=0.
  - Any late response is ignored; the memory must tolerate an abandoned request.

## Configuration
- **DMEM_TIMEOUT_EN defined:**
  - A counter of width clog2(TIMEOUT_CYCLES)+1 clears on entry to REQ and increments each cycle in REQ or RESP.
  - When it reaches TIMEOUT_CYCLES without completion: go to DONE, pulse err_o, drop d_req_o, load_ready_o=0, rdata_o unchanged.
  - A completion in the same cycle as the timeout wins; no err_o.
- **DMEM_TIMEOUT_EN undefined:**
  - No counter logic; err_o is tied to 0.
  - The FSM waits indefinitely for d_gnt_i and d_rvalid_i.

## Test plan
- SW, addr 0x100, wdata 0xDEADBEEF, be 1111, gnt immediate -> d_addr_o=0x100, d_we_o=1111 for one cycle; stall_o high 2 cycles; load_ready_o stays 0.
- LB at 0x203, d_rdata_i=0x80FF_FF7F -> rdata_o=0xFFFFFF80; LBU at the same address -> 0x00000080; load_ready_o pulses once each.
- LH at 0x202 with d_rdata_i=0x8001_1234 -> 0xFFFF8001; LW at 0x201 -> misaligned_o pulse, d_req_o never asserted, stall_o=0.
- Grant delayed 3 cycles -> d_req_o, d_addr_o and d_we_o are stable throughout; the spurious d_rvalid_i during REQ is ignored.
- rst_n_i pulled low while in RESP -> d_req_o=0 and state IDLE asynchronously; a subsequent d_rvalid_i does not change rdata_o.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=16, load whose rvalid never arrives -> err_o pulses on the 16th REQ/RESP cycle; stall_o drops; rdata_o unchanged.
